// File: rtl/nbit_pipe_addsub_if.sv
// nbit_pipe_addsub_if: operand/result streaming bundle for nbit_pipe_addsub.
// Ports: in_valid/in_ready + a, b, cin, sub; out_valid/out_ready + sum, cout, ovf.
interface nbit_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nbit_pipe_addsub.sv
// nbit_pipe_addsub: pipelined ripple-carry add/subtract, one CHUNK per stage.
// Ports: clk, rst (sync, active-high), bus (slave side of the stream bundle).
module nbit_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    nbit_pipe_addsub_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
        $error("nbit_pipe_addsub: WIDTH must be a positive multiple of STAGES");
    end

    logic              adv;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] cy;
    logic [WIDTH-1:0]  bp;
    logic              c0;

    // Global enable: the whole pipe moves or the whole pipe holds.
    assign adv          = !v[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    // Subtraction is a + ~b + !cin, so stage 0 sees the effective operand.
    assign bp = bus.sub ? ~bus.b : bus.b;
    assign c0 = bus.sub ? !bus.cin : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        logic [CHUNK-1:0] xa;
        logic [CHUNK-1:0] xb;
        logic             xc;
        logic             xv;
        logic [CHUNK:0]   t;
        logic [HI-1:0]    rs_d;
        logic [HI-1:0]    rs;
        logic             vr;
        logic             cr;

        // Remaining operand bits travel right-aligned, so the chunk a
        // stage consumes always sits in the low CHUNK bits of its source.
        if (k == 0) begin : g_in
            assign xa   = bus.a[CHUNK-1:0];
            assign xb   = bp[CHUNK-1:0];
            assign xc   = c0;
            assign xv   = bus.in_valid;
            assign rs_d = t[CHUNK-1:0];
        end else begin : g_in
            assign xa   = g_st[k-1].g_rem.ra[CHUNK-1:0];
            assign xb   = g_st[k-1].g_rem.rb[CHUNK-1:0];
            assign xc   = cy[k-1];
            assign xv   = v[k-1];
            assign rs_d = {t[CHUNK-1:0], g_st[k-1].rs};
        end

        assign t = {1'b0, xa} + {1'b0, xb} + {{CHUNK{1'b0}}, xc};

        always_ff @(posedge clk) begin
            if (rst) begin
                vr <= 1'b0;
                cr <= 1'b0;
                rs <= '0;
            end else if (adv) begin
                vr <= xv;
                cr <= t[CHUNK];
                rs <= rs_d;
            end
        end

        assign v[k]  = vr;
        assign cy[k] = cr;

        if (k < STAGES - 1) begin : g_rem
            logic [WIDTH-HI-1:0] ra;
            logic [WIDTH-HI-1:0] rb;
            logic [WIDTH-HI-1:0] ra_d;
            logic [WIDTH-HI-1:0] rb_d;

            if (k == 0) begin : g_src
                assign ra_d = bus.a[WIDTH-1:CHUNK];
                assign rb_d = bp[WIDTH-1:CHUNK];
            end else begin : g_src
                assign ra_d = g_st[k-1].g_rem.ra[WIDTH-LO-1:CHUNK];
                assign rb_d = g_st[k-1].g_rem.rb[WIDTH-LO-1:CHUNK];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ra <= '0;
                    rb <= '0;
                end else if (adv) begin
                    ra <= ra_d;
                    rb <= rb_d;
                end
            end
        end else begin : g_out
            logic ovf_r;

            // The top chunk holds both sign bits and the result sign.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (adv) begin
                    ovf_r <= (xa[CHUNK-1] == xb[CHUNK-1]) &&
                             (t[CHUNK-1] != xa[CHUNK-1]);
                end
            end

            assign bus.sum = rs;
            assign bus.ovf = ovf_r;
        end
    end

    assign bus.out_valid = v[STAGES-1];
    assign bus.cout      = cy[STAGES-1];
endmodule

// File: tb/tb_nbit_pipe_addsub.sv
// tb_nbit_pipe_addsub: directed and streamed checks of nbit_pipe_addsub,
// plus random sweeps over several WIDTH/STAGES shapes.
module tb_nbit_pipe_addsub;
    logic clk;
    logic rst;
    logic rst_sw;
    int   n_vec = 0;
    int   n_err = 0;
    int   sweep_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nbit_pipe_addsub_if #(.WIDTH(16)) bus ();

    nbit_pipe_addsub #(
        .WIDTH (16),
        .STAGES(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 8;
            1:       return 8;
            2:       return 32;
            default: return 12;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0:       return 1;
            1:       return 8;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    // One operation on an otherwise idle pipe: latency and all result fields.
    task automatic run_op(input string tag,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec,
                          input logic eo);
        int n;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
        bus.sub       = sb;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(4));
        chk({tag, "_sum"}, 64'(bus.sum), 64'(es));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    endtask

    task automatic stream_test();
        int          sent;
        int          got;
        logic        held;
        logic [17:0] hs;
        logic [15:0] e;
        sent = 0;
        got  = 0;
        held = 1'b0;
        hs   = '0;
        for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
            @(negedge clk);
            if (held) begin
                chk("stall_hold",
                    64'({bus.out_valid, bus.ovf, bus.cout, bus.sum}),
                    64'({1'b1, hs}));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_valid  = (sent < 64);
            bus.a         = 16'(sent);
            bus.b         = 16'(2 * sent);
            bus.cin       = sent[0];
            bus.sub       = 1'b0;
            #1;
            chk("in_ready_adv", 64'(bus.in_ready),
                64'(!bus.out_valid || bus.out_ready));
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                e = 16'(3 * got + (got % 2));
                chk("stream_sum", 64'(bus.sum), 64'(e));
                chk("stream_flags", 64'({bus.cout, bus.ovf}), 64'(0));
                got++;
            end
            held = bus.out_valid && !bus.out_ready;
            hs   = {bus.ovf, bus.cout, bus.sum};
        end
        chk("stream_count", 64'(got), 64'(64));
        bus.in_valid = 1'b0;
    endtask

    task automatic reset_mid_test();
        int stale;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'(16'h1111 * (k + 1));
            bus.b        = 16'h0001;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_mid_data", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("rst_stale", 64'(stale), 64'(0));
        run_op("post_rst", 16'h0100, 16'h0023, 1'b0, 1'b0,
               16'h0123, 1'b0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        rst_sw        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        rst_sw = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_sum", 64'(bus.sum), 64'(0));
        chk("rst_cout", 64'(bus.cout), 64'(0));
        chk("rst_ovf", 64'(bus.ovf), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

        run_op("add_wrap",   16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        run_op("sub_neg",    16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        run_op("sub_ovf",    16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        run_op("sub_bin",    16'h0010, 16'h0003, 1, 1, 16'h000C, 1, 0);
        run_op("add_cin",    16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0);
        run_op("add_negovf", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
        run_op("sub_zero",   16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 0);
        run_op("sub_borrow", 16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0);
        run_op("add_all1",   16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
        run_op("add_ripple", 16'h0FFF, 16'h0001, 0, 0, 16'h1000, 0, 0);

        stream_test();
        reset_mid_test();

        for (int t = 0; t < 20000 && sweep_done < 4; t++) @(negedge clk);
        chk("sweeps_finished", 64'(sweep_done), 64'(4));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W    = cfg_w(g);
        localparam int S    = cfg_s(g);
        localparam int NOPS = 1000;

        nbit_pipe_addsub_if #(.WIDTH(W)) sif ();

        nbit_pipe_addsub #(
            .WIDTH (W),
            .STAGES(S)
        ) u_sw (
            .clk(clk),
            .rst(rst_sw),
            .bus(sif.slave)
        );

        // Reference: plain subtraction with borrow, so cout = !borrow.
        function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic c,
                                               input logic s);
            logic [W:0] r;
            logic       o;
            if (s) begin
                r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
                o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
                return {o, ~r[W], r[W-1:0]};
            end
            r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            return {o, r[W], r[W-1:0]};
        endfunction

        initial begin : run
            logic [W+1:0] expq [$];
            logic [W+1:0] e;
            logic [W+1:0] hs;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rsb;
            logic         pend;
            logic         held;
            int           sent;
            int           got;
            int           n;

            sif.in_valid  = 1'b0;
            sif.a         = '0;
            sif.b         = '0;
            sif.cin       = 1'b0;
            sif.sub       = 1'b0;
            sif.out_ready = 1'b1;
            sent = 0;
            got  = 0;
            pend = 1'b0;
            held = 1'b0;
            hs   = '0;
            repeat (5) @(negedge clk);

            ra  = W'($urandom());
            rb  = W'($urandom());
            rc  = 1'($urandom());
            rsb = 1'($urandom());
            sif.a        = ra;
            sif.b        = rb;
            sif.cin      = rc;
            sif.sub      = rsb;
            sif.in_valid = 1'b1;
            e = model(ra, rb, rc, rsb);
            @(negedge clk);
            sif.in_valid = 1'b0;
            n = 1;
            while (!sif.out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("sw%0d_lat", g), 64'(n), 64'(S));
            chk($sformatf("sw%0d_first", g),
                64'({sif.ovf, sif.cout, sif.sum}), 64'(e));

            for (int cyc = 0; cyc < 6000 && got < NOPS; cyc++) begin
                @(negedge clk);
                if (held) begin
                    chk($sformatf("sw%0d_hold", g),
                        64'({sif.out_valid, sif.ovf, sif.cout, sif.sum}),
                        64'({1'b1, hs}));
                end
                if (!pend && sent < NOPS) begin
                    ra      = W'($urandom());
                    rb      = W'($urandom());
                    rc      = 1'($urandom());
                    rsb     = 1'($urandom());
                    sif.a   = ra;
                    sif.b   = rb;
                    sif.cin = rc;
                    sif.sub = rsb;
                    pend    = 1'b1;
                end
                sif.in_valid  = pend && ($urandom_range(0, 4) != 0);
                sif.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (sif.in_valid && sif.in_ready) begin
                    expq.push_back(model(ra, rb, rc, rsb));
                    pend = 1'b0;
                    sent++;
                end
                if (sif.out_valid && sif.out_ready) begin
                    e = (expq.size() != 0) ? expq.pop_front() : 'x;
                    chk($sformatf("sw%0d_res", g),
                        64'({sif.ovf, sif.cout, sif.sum}), 64'(e));
                    got++;
                end
                held = sif.out_valid && !sif.out_ready;
                hs   = {sif.ovf, sif.cout, sif.sum};
            end
            chk($sformatf("sw%0d_count", g), 64'(got), 64'(NOPS));
            sif.in_valid = 1'b0;
            sweep_done++;
        end
    end
endmodule

// File: doc/nbit_pipe_addsub.md
# nbit_pipe_addsub

Parametrised, pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit add or subtract into STAGES equal carry-chained chunks, computing one chunk per pipeline stage. It accepts one operation per clock under a valid/ready handshake with full backpressure. It is the registered, streaming successor to the combinational n-bit full-adder chain and sits between operand producers and any downstream consumer that can stall.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥1
- STAGES, 4, pipeline depth and chunk count; WIDTH % STAGES == 0 is required (elaboration error otherwise); CHUNK = WIDTH/STAGES
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

## Operation
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + !cin, i.e. a − b − cin; cout=1 means no borrow.
  - ovf = (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]), where b' = b or ~b per sub.
- Result is bit-exact to the single-cycle WIDTH-bit expression for all inputs.
- Stage k (0..STAGES−1):
  - adds bits [k·CHUNK +: CHUNK] of a and b' plus the carry registered by stage k−1 (stage 0 uses cin or !cin).
  - registers its CHUNK result bits, its carry, a valid bit, and the not-yet-consumed higher operand bits and lower result bits (skew registers).
- The final stage register drives sum, cout, ovf, out_valid directly. No combinational path from a/b to outputs.
- Flow control uses a global enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
  - When adv=1, every stage loads from its predecessor, and stage 0 loads in_valid plus operands.
  - When adv=0, all stages hold.
- Bubbles (invalid stages) propagate and are not compressed. Data registers of invalid stages are don't-care, but outputs must be stable while out_valid=1 && out_ready=0.
- Transfer in occurs on in_valid && in_ready; transfer out on out_valid && out_ready.

## Timing
- Reset: all stage valid bits cleared. out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the cycle after rst deasserts (in_ready=1 during rst is permitted but inputs are ignored).
- Reset mid-operation: all in-flight operations are discarded, with no partial result emitted.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles from acceptance to visibility.
- Throughput: one result per cycle while out_ready=1.
- Stall: out_ready low with out_valid=1 freezes the whole pipe, and in_ready drops the same cycle. Release gives the next result the following cycle, in order, with no loss or duplication.
- Simultaneous out transfer and in transfer in the same cycle is allowed (pipe shifts).
- STAGES=1 degenerates to one registered adder. STAGES=WIDTH gives 1-bit chunks. Both must work.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1, sub=0. Inputs a=0xFFFF, b=0x0001, cin=0 → 4 cycles later sum=0x0000, cout=1, ovf=0. Inputs a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. Inputs a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. Inputs a=0x0010, b=0x0003, cin=1 → sum=0x000C, cout=1.
- Back-to-back stream of a=i, b=2i, cin=i[0] for i=0..63 with out_ready toggled pseudo-randomly. Expected: 64 results in order, each sum=(3i+i[0]) mod 2^16, outputs stable during every stall, and in_ready==adv every cycle.
- Reset mid-stream: accept 3 ops, assert rst for 1 cycle. Expected: out_valid=0 and sum/cout/ovf=0 the next cycle, no stale result afterward; a new op after reset returns after 4 cycles.
- Parameter sweep {WIDTH,STAGES} = {8,1}, {8,8}, {32,4}, {12,3}: 1000 random ops each with both sub modes and random backpressure, compared against a reference model. Expected: zero mismatches and latency == STAGES.
